// File: rtl/classify_seq_ctrl_pkg.sv
// Package cnn_cls_pkg: shared types and constants for the CNN classification
// stage controller (classify_seq_ctrl).
//   cls_state_e  : controller states IDLE / ACCUM / DONE
//   CLS_N_CLASS  : default number of class scores per classification
//   CLS_DATA_W   : default signed score width
//   cls_idx_w(n) : category width able to hold 0..n (1-based class index, 0 = none)
package cnn_cls_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } cls_state_e;

  localparam int CLS_N_CLASS = 10;
  localparam int CLS_DATA_W  = 16;

  function automatic int cls_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/classify_seq_ctrl_if.sv
// Interface classify_seq_ctrl_if: score stream in, result handshake out.
//   slave  modport : the classify_seq_ctrl controller
//   master modport : score sequencer / result consumer side
//   in_valid, in_data, in_last, in_ready : score beat stream
//   out_valid, out_category, out_score, err_len, out_ack : result handshake
//   busy : classification in progress (first beat until ack)
// Optional (CLS_TOP2_EN): out_second (runner-up class), out_margin (max - runner-up).
interface classify_seq_ctrl_if
  import cnn_cls_pkg::*;
#(
  parameter int DATA_W = CLS_DATA_W,
  parameter int IDX_W  = cls_idx_w(CLS_N_CLASS)
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     in_ready;
  logic                     out_valid;
  logic [IDX_W-1:0]         out_category;
  logic signed [DATA_W-1:0] out_score;
  logic                     err_len;
  logic                     out_ack;
  logic                     busy;
`ifdef CLS_TOP2_EN
  logic [IDX_W-1:0]         out_second;
  logic [DATA_W:0]          out_margin;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ack,
    output in_ready, out_valid, out_category, out_score, err_len, busy
`ifdef CLS_TOP2_EN
    , output out_second, out_margin
`endif
  );

  modport master (
    output in_valid, in_data, in_last, out_ack,
    input  in_ready, out_valid, out_category, out_score, err_len, busy
`ifdef CLS_TOP2_EN
    , input out_second, out_margin
`endif
  );

endinterface

// File: rtl/classify_seq_ctrl_max_update.sv
// Module cls_max_update: combinational running-argmax step.
//   first      : this beat starts a new vector (load unconditionally)
//   cur_max/idx: running maximum and its 1-based class index
//   new_score  : incoming signed score, beat = its 1-based index
//   nxt_max/idx: updated maximum / index (strict compare, ties keep lower index)
// Optional (CLS_TOP2_EN): cur_sec/cur_sec_idx -> nxt_sec/nxt_sec_idx track the
// runner-up; a runner-up index of 0 marks an empty runner-up slot.
module cls_max_update #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     first,
  input  logic signed [DATA_W-1:0] cur_max,
  input  logic [IDX_W-1:0]         cur_idx,
`ifdef CLS_TOP2_EN
  input  logic signed [DATA_W-1:0] cur_sec,
  input  logic [IDX_W-1:0]         cur_sec_idx,
  output logic signed [DATA_W-1:0] nxt_sec,
  output logic [IDX_W-1:0]         nxt_sec_idx,
`endif
  input  logic signed [DATA_W-1:0] new_score,
  input  logic [IDX_W-1:0]         beat,
  output logic signed [DATA_W-1:0] nxt_max,
  output logic [IDX_W-1:0]         nxt_idx
);

  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
`ifdef CLS_TOP2_EN
    nxt_sec     = cur_sec;
    nxt_sec_idx = cur_sec_idx;
`endif
    if (first) begin
      nxt_max = new_score;
      nxt_idx = beat;
`ifdef CLS_TOP2_EN
      nxt_sec     = '0;
      nxt_sec_idx = '0;
`endif
    end else if (new_score > cur_max) begin
      nxt_max = new_score;
      nxt_idx = beat;
`ifdef CLS_TOP2_EN
      // displaced maximum becomes the runner-up
      nxt_sec     = cur_max;
      nxt_sec_idx = cur_idx;
`endif
    end
`ifdef CLS_TOP2_EN
    else if ((cur_sec_idx == '0) || (new_score > cur_sec)) begin
      nxt_sec     = new_score;
      nxt_sec_idx = beat;
    end
`endif
  end

endmodule

// File: rtl/classify_seq_ctrl.sv
// Module classify_seq_ctrl: streaming argmax controller for the CNN output stage.
// Accepts N_CLASS signed scores one per beat, tracks the running maximum and
// its 1-based index, and presents the winner with a valid/ack handshake.
// Ports:
//   clk     : clock, rising edge
//   n_reset : asynchronous active-low reset
//   bus     : classify_seq_ctrl_if.slave (score stream + result handshake)
// Build option: CLS_TOP2_EN adds runner-up index and margin outputs.
module classify_seq_ctrl
  import cnn_cls_pkg::*;
#(
  parameter int N_CLASS = CLS_N_CLASS,
  parameter int DATA_W  = CLS_DATA_W,
  parameter int IDX_W   = cls_idx_w(N_CLASS)
) (
  input logic                clk,
  input logic                n_reset,
  classify_seq_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_CLASS);

  cls_state_e               state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] max_q, max_d, upd_max;
  logic [IDX_W-1:0]         idx_q, idx_d, upd_idx;
  logic                     err_q, err_d;
  logic [IDX_W-1:0]         beat;
  logic                     xfer;
  logic                     ending;

  // counter saturates at N_CLASS; the vector always ends there anyway
  assign beat   = (cnt_q == N_IDX) ? N_IDX : cnt_q + 1'b1;
  assign xfer   = bus.in_valid && (state_q != DONE);
  assign ending = bus.in_last || (beat == N_IDX);

`ifdef CLS_TOP2_EN
  logic signed [DATA_W-1:0] sec_q, sec_d, upd_sec;
  logic [IDX_W-1:0]         sec_idx_q, sec_idx_d, upd_sec_idx;
  logic signed [DATA_W:0]   diff;
`endif

  cls_max_update #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_max_update (
    .first       (cnt_q == '0),
    .cur_max     (max_q),
    .cur_idx     (idx_q),
`ifdef CLS_TOP2_EN
    .cur_sec     (sec_q),
    .cur_sec_idx (sec_idx_q),
    .nxt_sec     (upd_sec),
    .nxt_sec_idx (upd_sec_idx),
`endif
    .new_score   (bus.in_data),
    .beat        (beat),
    .nxt_max     (upd_max),
    .nxt_idx     (upd_idx)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
`ifdef CLS_TOP2_EN
      sec_q     <= '0;
      sec_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
`ifdef CLS_TOP2_EN
      sec_q     <= sec_d;
      sec_idx_q <= sec_idx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    err_d     = err_q;
`ifdef CLS_TOP2_EN
    sec_d     = sec_q;
    sec_idx_d = sec_idx_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          cnt_d = beat;
          max_d = upd_max;
          idx_d = upd_idx;
`ifdef CLS_TOP2_EN
          sec_d     = upd_sec;
          sec_idx_d = upd_sec_idx;
`endif
          if (ending) begin
            state_d = DONE;
            // wrong length either way: early in_last, or no in_last at N_CLASS
            err_d   = bus.in_last ^ (beat == N_IDX);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (bus.out_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q != DONE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.out_category = (state_q == DONE) ? idx_q : '0;
  assign bus.out_score    = (state_q == DONE) ? max_q : '0;
  assign bus.err_len      = (state_q == DONE) && err_q;

`ifdef CLS_TOP2_EN
  assign diff           = {max_q[DATA_W-1], max_q} - {sec_q[DATA_W-1], sec_q};
  assign bus.out_second = (state_q == DONE) ? sec_idx_q : '0;
  assign bus.out_margin = ((state_q == DONE) && (sec_idx_q != '0)) ? $unsigned(diff) : '0;
`endif

endmodule
